// File: rtl/register_file.sv
// 32 x 32-bit register file feeding the ALU operand ports.
// Two combinational reads, one synchronous write, r0 reads as zero.
module register_file #(
    parameter int FORWARD = 0,
    parameter int WIDTH   = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       readAddr1,
    input  logic [4:0]       readAddr2,
    output logic [WIDTH-1:0] readData1,
    output logic [WIDTH-1:0] readData2,
    input  logic [4:0]       writeAddr,
    input  logic [WIDTH-1:0] writeData,
    input  logic             writeEnable
);

    logic [WIDTH-1:0] regs [1:31];
    logic [WIDTH-1:0] regView [0:31];
    logic [31:0]      writeSel;
    logic             hit1;
    logic             hit2;

    always_comb begin
        writeSel = '0;
        if (writeEnable) begin
            writeSel[writeAddr] = 1'b1;
        end
        writeSel[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 1; i < 32; i++) begin
                regs[i] <= '0;
            end
        end else begin
            for (int i = 1; i < 32; i++) begin
                if (writeSel[i]) begin
                    regs[i] <= writeData;
                end
            end
        end
    end

    // r0 has no storage; the view gives the read muxes a full 32-entry table
    always_comb begin
        regView[0] = '0;
        for (int i = 1; i < 32; i++) begin
            regView[i] = regs[i];
        end
    end

    always_comb begin
        hit1 = (FORWARD != 0) && !reset && writeSel[readAddr1];
        hit2 = (FORWARD != 0) && !reset && writeSel[readAddr2];
    end

    assign readData1 = hit1 ? writeData : regView[readAddr1];
    assign readData2 = hit2 ? writeData : regView[readAddr2];

endmodule

// File: tb/tb_register_file.sv
// Bench for register_file: both FORWARD settings driven in lockstep,
// checked each cycle against an array model plus literal expectations.
module tb_register_file;

    logic        clk;
    logic        reset;
    logic [4:0]  readAddr1;
    logic [4:0]  readAddr2;
    logic [4:0]  writeAddr;
    logic [31:0] writeData;
    logic        writeEnable;
    logic [31:0] rd1F0, rd2F0, rd1F1, rd2F1;

    int checks = 0;
    int errors = 0;

    logic [31:0] model [0:31];
    bit          modelValid = 0;

    register_file #(.FORWARD(0), .WIDTH(32)) dutF0 (
        .clk(clk), .reset(reset),
        .readAddr1(readAddr1), .readAddr2(readAddr2),
        .readData1(rd1F0), .readData2(rd2F0),
        .writeAddr(writeAddr), .writeData(writeData),
        .writeEnable(writeEnable)
    );

    register_file #(.FORWARD(1), .WIDTH(32)) dutF1 (
        .clk(clk), .reset(reset),
        .readAddr1(readAddr1), .readAddr2(readAddr2),
        .readData1(rd1F1), .readData2(rd2F1),
        .writeAddr(writeAddr), .writeData(writeData),
        .writeEnable(writeEnable)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    // Architectural model: state change at the edge
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) model[i] = 32'h0;
            modelValid = 1;
        end else if (writeEnable && writeAddr != 5'd0) begin
            model[writeAddr] = writeData;
        end
    end

    function automatic logic [31:0] expRead(input logic [4:0] a, input bit fwd);
        if (a == 5'd0) return 32'h0;
        if (fwd && !reset && writeEnable && writeAddr == a) return writeData;
        return model[a];
    endfunction

    task automatic cmp(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s t=%0t got %h expected %h", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (modelValid) begin
            cmp("f0.port1", rd1F0, expRead(readAddr1, 0));
            cmp("f0.port2", rd2F0, expRead(readAddr2, 0));
            cmp("f1.port1", rd1F1, expRead(readAddr1, 1));
            cmp("f1.port2", rd2F1, expRead(readAddr2, 1));
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    function automatic logic [31:0] alu(input logic [2:0] cmd,
                                        input logic [31:0] a,
                                        input logic [31:0] b);
        case (cmd)
            3'b000:  return a + b;
            3'b001:  return a - b;
            3'b011:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: return 32'h0;
        endcase
    endfunction

    initial begin
        reset = 1; writeEnable = 0; writeAddr = 0; writeData = 0;
        readAddr1 = 0; readAddr2 = 0;
        #1;
        cmp("r0.prereset", rd1F0, 32'h0);
        step();
        reset = 0;

        for (int i = 0; i < 32; i++) begin
            readAddr1 = 5'(i);
            readAddr2 = 5'(31 - i);
            #1;
            cmp("reset.clear1", rd1F0, 32'h0);
            cmp("reset.clear2", rd2F1, 32'h0);
            step();
        end

        for (int i = 1; i < 32; i++) begin
            writeEnable = 1;
            writeAddr = 5'(i);
            writeData = 32'hA5A5_0000 + 32'(i);
            step();
        end
        writeEnable = 0;

        for (int i = 0; i < 32; i++) begin
            readAddr1 = 5'(i);
            readAddr2 = 5'(i);
            #1;
            cmp("wall.f0p1", rd1F0, (i == 0) ? 32'h0 : 32'hA5A5_0000 + 32'(i));
            cmp("wall.f1p2", rd2F1, (i == 0) ? 32'h0 : 32'hA5A5_0000 + 32'(i));
            step();
        end

        writeEnable = 1; writeAddr = 0; writeData = 32'hFFFF_FFFF;
        readAddr1 = 0;
        #1;
        cmp("r0.fwd", rd1F1, 32'h0);
        step();
        writeEnable = 0;
        #1;
        cmp("r0.immut", rd1F0, 32'h0);

        writeEnable = 1; writeAddr = 5; writeData = 32'h1111_1111;
        step();
        writeData = 32'h2222_2222;
        readAddr1 = 5; readAddr2 = 5;
        #1;
        cmp("haz.f0.pre", rd1F0, 32'h1111_1111);
        cmp("haz.f0.pre2", rd2F0, 32'h1111_1111);
        cmp("haz.f1.pre", rd1F1, 32'h2222_2222);
        cmp("haz.f1.pre2", rd2F1, 32'h2222_2222);
        step();
        writeEnable = 0;
        #1;
        cmp("haz.f0.post", rd1F0, 32'h2222_2222);
        cmp("haz.f1.post", rd2F1, 32'h2222_2222);

        writeEnable = 1; writeAddr = 7; writeData = 32'h1234_5678;
        step();
        reset = 1; writeData = 32'hDEAD_BEEF; readAddr1 = 7; readAddr2 = 7;
        #1;
        cmp("rst.nofwd", rd1F1, 32'h1234_5678);
        step();
        reset = 0; writeEnable = 0;
        #1;
        cmp("rst.prio.f0", rd1F0, 32'h0);
        cmp("rst.prio.f1", rd2F1, 32'h0);
        readAddr1 = 5;
        #1;
        cmp("rst.r5", rd1F0, 32'h0);
        writeEnable = 1; writeAddr = 7; writeData = 32'hDEAD_BEEF;
        readAddr1 = 7;
        step();
        writeEnable = 0;
        #1;
        cmp("rst.rewrite", rd1F0, 32'hDEAD_BEEF);

        writeEnable = 1; writeAddr = 1; writeData = 32'd7;
        step();
        writeAddr = 2; writeData = 32'd9;
        step();
        writeEnable = 0; readAddr1 = 1; readAddr2 = 2;
        #1;
        writeEnable = 1; writeAddr = 3;
        writeData = alu(3'b001, rd1F0, rd2F0);
        step();
        writeAddr = 4;
        writeData = alu(3'b011, rd1F0, rd2F0);
        step();
        writeEnable = 0; readAddr1 = 3; readAddr2 = 4;
        #1;
        cmp("alu.sub", rd1F0, 32'hFFFF_FFFE);
        cmp("alu.slt", rd2F0, 32'h0000_0001);
        cmp("alu.sub.f1", rd1F1, 32'hFFFF_FFFE);
        cmp("alu.slt.f1", rd2F1, 32'h0000_0001);
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/register_file.md
# register_file

32-entry × 32-bit general-purpose register file that sits directly upstream of the 32-bit ALU.
- Two combinational read ports drive the ALU's `operandA` and `operandB`.
- One synchronous write port accepts the ALU `result`, or any other writeback value, at the clock edge.
- Register 0 is hardwired to zero, so `operandB = 0` for compares and moves needs no extra logic.

## Interface
Parameters:
- `FORWARD`, default 0 — when 1, a read of the register being written in the same cycle returns `writeData`; when 0, it returns the stored value.
- `WIDTH`, default 32 — data width. Fixed at 32 to match the ALU; other values are unsupported.

Ports:
- `clk` input 1 — single clock; all state changes on its rising edge.
- `reset` input 1 — synchronous, active-high; clears every register on a rising `clk` edge while high.
- `readAddr1` input 5 — register index for read port 1.
- `readAddr2` input 5 — register index for read port 2.
- `readData1` output 32 — contents of `readAddr1`; feeds ALU `operandA`.
- `readData2` output 32 — contents of `readAddr2`; feeds ALU `operandB`.
- `writeAddr` input 5 — register index for the write port.
- `writeData` input 32 — value to write; normally ALU `result`.
- `writeEnable` input 1 — commits `writeData` to `writeAddr` at the next rising edge.

## Operation
- Storage: registers r1..r31 are 32-bit state. r0 has no storage and always reads 0x00000000.
- Write: on a rising `clk` edge with `writeEnable`=1, `reset`=0 and `writeAddr`≠0, r[`writeAddr`] ← `writeData`.
  - All other registers hold their value.
  - A write to r0 is silently discarded.
- Write decode: a 5→32 one-hot decoder gated by `writeEnable`; bit 0 of the decoded vector is forced low.
- Read: `readData1` = r[`readAddr1`] and `readData2` = r[`readAddr2`], as purely combinational 32:1 muxes.
  - Both ports are independent; both may address the same register.
- Forwarding, `FORWARD`=1 only: if `writeEnable`=1, `writeAddr`≠0 and `readAddrN`=`writeAddr`, then `readDataN`=`writeData` in the same cycle. This applies per port.
- Forwarding with `FORWARD`=0: the read returns the pre-edge value; the new value is visible after the edge.
- Reset priority: `reset` beats `writeEnable`. A write presented in a reset cycle is lost.
- Forwarding during reset: suppressed while `reset`=1. Reads show the stored contents in that cycle.
- Unknown inputs: X on `writeEnable` or `writeAddr` is not required to be tolerated; the bench keeps them driven.

## Timing
- Reset values: after one rising edge with `reset`=1, r1..r31 = 0.
  - `readData1` and `readData2` read 0 for every address from then on, until the first write.
- Pre-reset state: register contents before the first reset edge are undefined (X in simulation). Outputs for r0 are 0 at all times.
- Write latency: data is visible on a read port (`FORWARD`=0) in the cycle after the committing edge, i.e. 1 cycle.
- Read latency: 0 cycles; a change in `readAddrN` propagates combinationally to `readDataN`.
- Write-then-read, same cycle:
  - `FORWARD`=0: old value.
  - `FORWARD`=1: new value.
  - Either way, the stored value after the edge is the new value.
- Back-to-back writes to the same register: the last committed write wins, one per cycle.
- Reset asserted mid-sequence: the edge with `reset`=1 clears everything, including any write in that cycle. The first write after reset commits on the first edge with `reset`=0.
- Critical path: `readAddr` → mux → ALU → `writeData` is one combinational path per cycle. This block adds only mux delay, plus a compare and mux when `FORWARD`=1.

## Test plan
- Reset clear: hold `reset`=1 for 1 edge, then sweep `readAddr1`/`readAddr2` over 0..31 → every read is 0x00000000.
- Write/read all registers:
  - Stimulus: write r[i] ← 0xA5A50000+i for i=1..31, then read back on both ports.
  - Required: each returns 0xA5A50000+i, and r0 reads 0.
- r0 immutability: write 0xFFFFFFFF to `writeAddr`=0, `writeEnable`=1 → next cycle `readData1` with `readAddr1`=0 is 0x00000000.
- Same-cycle hazard, r5 holding 0x11111111:
  - Stimulus: write r5 ← 0x22222222 while `readAddr1`=`readAddr2`=5.
  - Required before the edge: `FORWARD`=0 reads 0x11111111; `FORWARD`=1 reads 0x22222222.
  - Required after the edge: both configurations read 0x22222222.
- Reset priority:
  - Stimulus: with r7=0x12345678, assert `reset`=1 together with `writeEnable`=1, `writeAddr`=7, `writeData`=0xDEADBEEF.
  - Required: after the edge r7=0.
  - Then, with `reset`=0, writing 0xDEADBEEF → r7=0xDEADBEEF one cycle later.
- ALU loop:
  - Stimulus: r1=7, r2=9. Read r1/r2 into the ALU with `command`=001 (sub) and write `result` to r3; then `command`=011 (SLT) into r4.
  - Required: r3=0xFFFFFFFE and r4=0x00000001.
